dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port byte-addressed data RAM. Shares the RAM between the CPU load/store port and a DMA/loader port using round-robin arbitration with a req/gnt handshake. Word stores go out in one access cycle. Sub-word stores run a read-modify-write sequence. Also corrects the RAM's byte-reversed write lane order, so a write followed by a read of the same word round-trips.

---
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin CPU/DMA arbiter and access sequencer for a single-port, byte-lane-reversed data RAM.
// Optional build macro DMEM_ARB_SUBWORD_EN enables byte/half stores through a read-modify-write path.
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req_i,
    input  logic                     cpu_we_i,
    input  logic [1:0]               cpu_size_i,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata_i,
    output logic                     cpu_gnt_o,
    output logic                     cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0]    cpu_rdata_o,
    input  logic                     dma_req_i,
    input  logic                     dma_we_i,
    input  logic [1:0]               dma_size_i,
    input  logic [ADDRESS_WIDTH-1:0] dma_addr_i,
    input  logic [DATA_WIDTH-1:0]    dma_wdata_i,
    output logic                     dma_gnt_o,
    output logic                     dma_rvalid_o,
    output logic [DATA_WIDTH-1:0]    dma_rdata_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wd_o,
    input  logic [DATA_WIDTH-1:0]    mem_rd_i
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RMW_WR = 2'd2} state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    state_t                   state_q, state_d;
    logic                     last_q, last_d;
    logic                     any_req, win_id;
    logic                     id_q, we_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     cpu_rvalid_q, dma_rvalid_q;
    logic [DATA_WIDTH-1:0]    cpu_rdata_q, dma_rdata_q;

    // The RAM writes byte addr+k from the top lane down, so pre-reverse the lanes.
    function automatic logic [DATA_WIDTH-1:0] lane_rev(input logic [DATA_WIDTH-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign any_req = cpu_req_i | dma_req_i;
    assign win_id  = (cpu_req_i & dma_req_i) ? ~last_q : dma_req_i;

`ifdef DMEM_ARB_SUBWORD_EN
    logic [1:0]               size_q;
    logic [DATA_WIDTH-1:0]    merge_q, merged;
    logic [ADDRESS_WIDTH-1:0] addr_aligned;
    logic                     sub_store;

    assign sub_store    = we_q & ~size_q[1];
    assign addr_aligned = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};

    always_comb begin
        merged = merge_q;
        if (size_q[0] == 1'b0) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end
`else
    logic unused_size;
    assign unused_size = ^{cpu_size_i, dma_size_i};
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cpu_gnt_o  = 1'b0;
        dma_gnt_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        case (state_q)
            IDLE: begin
                if (rst_n && any_req) begin
                    cpu_gnt_o = (win_id == PORT_CPU);
                    dma_gnt_o = (win_id == PORT_DMA);
                    last_d    = win_id;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                state_d    = IDLE;
                mem_addr_o = addr_q;
                mem_we_o   = we_q;
                mem_wd_o   = we_q ? lane_rev(wdata_q) : '0;
`ifdef DMEM_ARB_SUBWORD_EN
                if (sub_store) begin
                    mem_addr_o = addr_aligned;
                    mem_we_o   = 1'b0;
                    mem_wd_o   = '0;
                    state_d    = RMW_WR;
                end
`endif
            end
`ifdef DMEM_ARB_SUBWORD_EN
            RMW_WR: begin
                state_d    = IDLE;
                mem_addr_o = addr_aligned;
                mem_we_o   = 1'b1;
                mem_wd_o   = lane_rev(merged);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= PORT_DMA;
            id_q         <= PORT_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
`ifdef DMEM_ARB_SUBWORD_EN
            size_q       <= 2'b10;
            merge_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            if (state_q == IDLE && any_req) begin
                id_q    <= win_id;
                we_q    <= win_id ? dma_we_i : cpu_we_i;
                addr_q  <= win_id ? dma_addr_i : cpu_addr_i;
                wdata_q <= win_id ? dma_wdata_i : cpu_wdata_i;
`ifdef DMEM_ARB_SUBWORD_EN
                size_q  <= win_id ? dma_size_i : cpu_size_i;
`endif
            end
            if (state_q == ACCESS && !we_q) begin
                if (id_q == PORT_CPU) begin
                    cpu_rdata_q  <= mem_rd_i;
                    cpu_rvalid_q <= 1'b1;
                end else begin
                    dma_rdata_q  <= mem_rd_i;
                    dma_rvalid_q <= 1'b1;
                end
            end
`ifdef DMEM_ARB_SUBWORD_EN
            if (state_q == ACCESS && sub_store) begin
                merge_q <= mem_rd_i;
            end
`endif
        end
    end

    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dma_rvalid_o = dma_rvalid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign dma_rdata_o  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: lane-reversed RAM model plus a byte-array reference memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [1:0]  cpu_size, dma_size;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        ram_clear;
    logic [7:0]  ram [0:255];
    logic [7:0]  ref_mem [0:255];
    logic        last_win;
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_size_i(cpu_size),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_size_i(dma_size),
        .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
    );

    // RAM: combinational read, byte addr+k on [8k+7:8k]; writes take byte addr+k from the reversed lane.
    always_comb begin
        mem_rd = '0;
        for (int k = 0; k < 4; k++) mem_rd[8*k +: 8] = ram[8'(mem_addr + 32'(k))];
    end

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++) ram[8'(mem_addr + 32'(k))] <= mem_wd[8*(3-k) +: 8];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rev32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[8'(a + 3)], ref_mem[8'(a + 2)], ref_mem[8'(a + 1)], ref_mem[8'(a)]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            dma_req = 1'b1; dma_we = we; dma_size = size; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // One complete transaction on one port, starting with the DUT idle; returns load data.
    task automatic do_access(input bit port, input bit we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] got);
        int          wait_n;
        bit          sub;
        logic [31:0] expw;
        logic [31:0] base;
        got  = '0;
        expw = '0;
`ifdef DMEM_ARB_SUBWORD_EN
        sub = we && (size[1] == 1'b0);
`else
        sub = 1'b0;
`endif
        drive(port, we, size, addr, wdata);
        #1;
        wait_n = 0;
        while (!(port ? dma_gnt : cpu_gnt) && wait_n < 10) begin
            step();
            #1;
            wait_n++;
        end
        chk("gnt_latency", 32'(wait_n), 32'd0);
        if (wait_n >= 10) begin
            cpu_req = 1'b0;
            dma_req = 1'b0;
            return;
        end
        chk("gnt_other", 32'(port ? cpu_gnt : dma_gnt), 32'd0);
        last_win = port;
        step();
        if (port) dma_req = 1'b0; else cpu_req = 1'b0;
        #1;
        chk("busy_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        if (!we) begin
            expw = ref_word(addr);
            chk("load_we", 32'(mem_we), 32'd0);
            chk("load_addr", mem_addr, addr);
        end else if (!sub) begin
            chk("wst_we", 32'(mem_we), 32'd1);
            chk("wst_addr", mem_addr, addr);
            chk("wst_wd", mem_wd, rev32(wdata));
            for (int k = 0; k < 4; k++) ref_mem[8'(addr + 32'(k))] = wdata[8*k +: 8];
        end else begin
            chk("rmw_rd_we", 32'(mem_we), 32'd0);
            chk("rmw_rd_addr", mem_addr, {addr[31:2], 2'b00});
        end
        step();
        #1;
        if (!we) begin
            chk("rvalid_own", 32'(port ? dma_rvalid : cpu_rvalid), 32'd1);
            chk("rvalid_other", 32'(port ? cpu_rvalid : dma_rvalid), 32'd0);
            got = port ? dma_rdata : cpu_rdata;
            chk("load_data", got, expw);
        end else if (!sub) begin
            chk("wst_done_we", 32'(mem_we), 32'd0);
        end else begin
            if (size[0] == 1'b0) begin
                ref_mem[addr[7:0]] = wdata[7:0];
            end else begin
                base = {addr[31:1], 1'b0};
                ref_mem[base[7:0]]        = wdata[7:0];
                ref_mem[8'(base + 32'd1)] = wdata[15:8];
            end
            expw = ref_word({addr[31:2], 2'b00});
            chk("rmw_wr_we", 32'(mem_we), 32'd1);
            chk("rmw_wr_addr", mem_addr, {addr[31:2], 2'b00});
            chk("rmw_wr_wd", mem_wd, rev32(expw));
            step();
            #1;
        end
    endtask

    initial begin
        logic [31:0] got;
        bit          exp_port;
        rst_n = 1'b0; ram_clear = 1'b1; last_win = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h10; cpu_wdata = '0;
        dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b10; dma_addr = 32'h20; dma_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        // Reset holds everything quiet even with both requests raised.
        step(); step();
        ram_clear = 1'b0;
        #1;
        chk("rst_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("first_gnt_cpu", {30'd0, cpu_gnt, dma_gnt}, 32'b10);
        last_win = 1'b0;
        step();
        cpu_req = 1'b0; dma_req = 1'b0;
        step();
        #1;
        chk("first_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'b10);

        // Word round trip through the lane-reversed RAM.
        do_access(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, got);
        do_access(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, got);
        chk("deadbeef_load", got, 32'hDEADBEEF);

        do_access(1'b1, 1'b1, 2'b10, 32'h10, 32'h11223344, got);
`ifdef DMEM_ARB_SUBWORD_EN
        do_access(1'b0, 1'b1, 2'b00, 32'h11, 32'h000000AA, got);
        do_access(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, got);
        chk("byte_merge", got, 32'h1122AA44);
        do_access(1'b1, 1'b1, 2'b01, 32'h12, 32'h0000BEEF, got);
        do_access(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, got);
        chk("half_merge", got, 32'hBEEFAA44);

        // Reset during the RMW read phase must leave the RAM untouched.
        drive(1'b0, 1'b1, 2'b00, 32'h10, 32'h00000055);
        #1;
        chk("abort_rmw_gnt", 32'(cpu_gnt), 32'd1);
        step();
        cpu_req = 1'b0;
        #1;
        chk("abort_rmw_access_we", 32'(mem_we), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_rmw_rst_we", 32'(mem_we), 32'd0);
        last_win = 1'b1;
        step();
        chk("abort_rmw_hold_we", 32'(mem_we), 32'd0);
        rst_n = 1'b1;
        step();
        chk("abort_rmw_after_we", 32'(mem_we), 32'd0);
        do_access(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, got);
        chk("abort_rmw_unchanged", got, 32'hBEEFAA44);
`else
        do_access(1'b0, 1'b1, 2'b00, 32'h10, 32'h000000AA, got);
        do_access(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, got);
        chk("no_subword_word", got, 32'h000000AA);
`endif

        // Reset during a load's RAM-read cycle suppresses its rvalid.
        drive(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        #1;
        chk("abort_ld_gnt", 32'(dma_gnt), 32'd1);
        step();
        dma_req = 1'b0;
        rst_n = 1'b0;
        last_win = 1'b1;
        #1;
        chk("abort_ld_rst_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("abort_ld_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
        step();

        // Random single-port traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 32'($urandom_range(0, 252)), $urandom, got);
        end
        do_access(1'b1, 1'b0, 2'b10, 32'h20, 32'h0, got);

        // Both ports saturated with loads: grants alternate and rvalid follows the winner.
        drive(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 2'b10, 32'($urandom_range(0, 63) * 4), 32'h0);
        #1;
        for (int g = 0; g < 6; g++) begin
            exp_port = !last_win;
            chk("rr_gnt", {30'd0, cpu_gnt, dma_gnt}, exp_port ? 32'b01 : 32'b10);
            last_win = exp_port;
            step();
            #1;
            chk("rr_busy_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
            step();
            #1;
            chk("rr_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, exp_port ? 32'b01 : 32'b10);
            chk("rr_rdata", exp_port ? dma_rdata : cpu_rdata,
                ref_word(exp_port ? dma_addr : cpu_addr));
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
